// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready streaming.
// Prefix levels are split across STAGES register levels; the last register holds S and ovf.
module bk_adder_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   S,
   output logic             ovf
);
   localparam int LOG    = $clog2(WIDTH);
   localparam int LEVELS = 2 * LOG - 1;
   localparam int MID    = (STAGES > 1) ? STAGES - 1 : 1;
   localparam int GPW    = 2 * WIDTH;

   function automatic int cut(input int s);
      return (s * LEVELS + STAGES - 1) / STAGES;
   endfunction

   // One prefix level on {g, p}: up-sweep for lv < LOG, down-sweep afterwards.
   function automatic logic [GPW-1:0] bk_level(input int lv, input logic [GPW-1:0] gp);
      logic [WIDTH-1:0] g, p, sel;
      int span;
      g   = gp[GPW-1:WIDTH];
      p   = gp[WIDTH-1:0];
      sel = '0;
      span = (lv < LOG) ? (1 << lv) : (1 << (2 * LOG - 2 - lv));
      for (int i = 0; i < WIDTH; i++) begin
         if (lv < LOG) begin
            if ((i + 1) % (2 * span) == 0) sel |= WIDTH'(1) << i;
         end else if (((i + 1) % (2 * span) == span) && (i + 1 > 2 * span)) begin
            sel |= WIDTH'(1) << i;
         end
      end
      return {g | (sel & p & (g << span)), p & (~sel | (p << span))};
   endfunction

   function automatic logic [GPW-1:0] bk_range(input int lo, input int hi,
                                                input logic [GPW-1:0] gp);
      logic [GPW-1:0] r;
      r = gp;
      for (int lv = 0; lv < LEVELS; lv++) begin
         if (lv >= lo && lv < hi) r = bk_level(lv, r);
      end
      return r;
   endfunction

   logic [STAGES-1:0] r_vld, w_ready, w_in_vld, w_in_c0;
   logic [GPW-1:0]    w_in_gp  [STAGES];
   logic [GPW-1:0]    w_out_gp [STAGES];
   logic [WIDTH-1:0]  w_in_hs  [STAGES];
   logic [GPW-1:0]    r_gp [MID];
   logic [WIDTH-1:0]  r_hs [MID];
   logic [MID-1:0]    r_c0;
   logic [WIDTH-1:0]  w_y, w_p, w_g, w_cy;
   logic              w_c0, w_cout, w_ovf, w_unused_p;
   logic [WIDTH:0]    w_sum, r_s;
   logic              r_ovf;

   assign w_y  = sub ? ~Y : Y;
   assign w_c0 = sub ? ~Cin : Cin;
   assign w_p  = X ^ w_y;
   // Carry-in folded into bit-0 generate so every prefix G already includes it.
   assign w_g  = (X & w_y) | {{(WIDTH-1){1'b0}}, w_p[0] & w_c0};

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_head
         assign w_in_vld[s] = in_valid;
         assign w_in_gp[s]  = {w_g, w_p};
         assign w_in_hs[s]  = w_p;
         assign w_in_c0[s]  = w_c0;
      end else begin : g_tail
         assign w_in_vld[s] = r_vld[s-1];
         assign w_in_gp[s]  = r_gp[s-1];
         assign w_in_hs[s]  = r_hs[s-1];
         assign w_in_c0[s]  = r_c0[s-1];
      end
      assign w_out_gp[s] = bk_range(cut(s), cut(s + 1), w_in_gp[s]);
   end

   // A stage can take data if it, or any stage after it, is empty, or the output drains.
   always_comb begin
      w_ready = '0;
      for (int s = 0; s < STAGES; s++) begin
         w_ready[s] = out_ready;
         for (int j = s; j < STAGES; j++) begin
            if (!r_vld[j]) w_ready[s] = 1'b1;
         end
      end
   end

   assign w_cy       = {w_out_gp[STAGES-1][GPW-2:WIDTH], w_in_c0[STAGES-1]};
   assign w_cout     = w_out_gp[STAGES-1][GPW-1];
   assign w_sum      = {w_cout, w_in_hs[STAGES-1] ^ w_cy};
   assign w_ovf      = w_cy[WIDTH-1] ^ w_cout;
   assign w_unused_p = ^w_out_gp[STAGES-1][WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (w_ready[s]) r_vld[s] <= w_in_vld[s];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < STAGES - 1; s++) begin
            r_gp[s] <= '0;
            r_hs[s] <= '0;
            r_c0[s] <= 1'b0;
         end
      end else begin
         for (int s = 0; s < STAGES - 1; s++) begin
            if (w_ready[s] && w_in_vld[s]) begin
               r_gp[s] <= w_out_gp[s];
               r_hs[s] <= w_in_hs[s];
               r_c0[s] <= w_in_c0[s];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s   <= '0;
         r_ovf <= 1'b0;
      end else if (w_ready[STAGES-1] && w_in_vld[STAGES-1]) begin
         r_s   <= w_sum;
         r_ovf <= w_ovf;
      end
   end

   assign in_ready  = w_ready[0];
   assign out_valid = r_vld[STAGES-1];
   assign S         = r_s;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Self-checking bench for bk_adder_pipe (WIDTH=16, STAGES=3) against an arithmetic model.
module tb_bk_adder_pipe;
   localparam int W  = 16;
   localparam int ST = 3;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, Cin, sub, out_valid, out_ready, ovf;
   logic [W-1:0] X, Y;
   logic [W:0]   S;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc   = 0;
   logic       last_acc, last_rdy;
   logic [W:0] exp_s[$];
   logic       exp_o[$];
   logic [W:0] got_s[$];
   logic       got_o[$];
   int         got_c[$];

   always #5 clk = ~clk;

   bk_adder_pipe #(.WIDTH(W), .STAGES(ST)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y),
      .Cin(Cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .S(S), .ovf(ovf)
   );

   // {ovf, S} from plain integer arithmetic.
   function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sb);
      int sa, sbb, r, u;
      sa  = $signed(a);
      sbb = $signed(b);
      if (sb) begin
         r = sa - sbb - int'(ci);
         u = int'(a) - int'(b) - int'(ci) + (1 << W);
      end else begin
         r = sa + sbb + int'(ci);
         u = int'(a) + int'(b) + int'(ci);
      end
      return {(r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1))), u[W:0]};
   endfunction

   // Called at a negedge with inputs set; records transfers, returns at next negedge.
   task automatic step();
      logic [W+1:0] res;
      #1;
      last_acc = in_valid && in_ready;
      last_rdy = in_ready;
      if (out_valid && out_ready) begin
         got_s.push_back(S);
         got_o.push_back(ovf);
         got_c.push_back(cyc);
      end
      if (last_acc) begin
         res = ref_op(X, Y, Cin, sub);
         exp_s.push_back(res[W:0]);
         exp_o.push_back(res[W+1]);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic clear_q();
      exp_s.delete(); exp_o.delete(); got_s.delete(); got_o.delete(); got_c.delete();
   endtask

   task automatic rand_op();
      X   = W'($urandom);
      Y   = W'($urandom);
      Cin = 1'($urandom);
      sub = 1'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      X = '0; Y = '0; Cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_vec++;
      if ({ovf, S} !== 18'h0) begin
         n_err++; $display("FAIL reset_S_ovf: got %h want 0", {ovf, S});
      end
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_single();
      clear_q();
      X = 16'h000A; Y = 16'h0005; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (out_valid !== 1'(i == 2)) begin
            n_err++; $display("FAIL single_valid[%0d]: got %b want %b", i, out_valid, i == 2);
         end
         if (i == 2) begin
            n_vec++;
            if ({ovf, S} !== 18'h0000F) begin
               n_err++; $display("FAIL single_result: got %h want 0000f", {ovf, S});
            end
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] xs[3], ys[3];
      logic         cs[3];
      logic [W+1:0] want[3];
      xs = '{16'hFFFF, 16'hAAAA, 16'h7FFF};
      ys = '{16'h0001, 16'h5555, 16'h0001};
      cs = '{1'b0, 1'b1, 1'b0};
      want = '{18'h10000, 18'h10000, 18'h28000};
      clear_q();
      out_ready = 1'b1; sub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         X = xs[i]; Y = ys[i]; Cin = cs[i]; in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      for (int g = 0; g < 20 && got_s.size() < 3; g++) step();
      n_vec++;
      if (got_s.size() != 3) begin
         n_err++; $display("FAIL b2b_count: got %0d want 3", got_s.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({got_o[i], got_s[i]} !== want[i]) begin
               n_err++; $display("FAIL b2b_result[%0d]: got %h want %h", i, {got_o[i], got_s[i]},
                                 want[i]);
            end
            n_vec++;
            if (got_c[i] != got_c[0] + i) begin
               n_err++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", i, got_c[i], got_c[0] + i);
            end
         end
      end
   endtask

   task automatic test_sub();
      logic [W-1:0] xs[3], ys[3];
      logic         cs[3];
      logic [W+1:0] want[3];
      xs = '{16'h0005, 16'h8000, 16'h0010};
      ys = '{16'h000A, 16'h0001, 16'h0010};
      cs = '{1'b0, 1'b0, 1'b1};
      want = '{18'h0FFFB, 18'h37FFF, 18'h0FFFF};
      clear_q();
      out_ready = 1'b1; sub = 1'b1;
      for (int i = 0; i < 3; i++) begin
         X = xs[i]; Y = ys[i]; Cin = cs[i]; in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0; sub = 1'b0;
      for (int g = 0; g < 20 && got_s.size() < 3; g++) step();
      n_vec++;
      if (got_s.size() != 3) begin
         n_err++; $display("FAIL sub_count: got %0d want 3", got_s.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({got_o[i], got_s[i]} !== want[i]) begin
               n_err++; $display("FAIL sub_result[%0d]: got %h want %h", i, {got_o[i], got_s[i]},
                                 want[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int         n_acc, n_done;
      logic       held_ok;
      logic [W:0] held;
      clear_q();
      out_ready = 1'b1; rand_op(); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int g = 0; g < 10 && got_s.size() < 1; g++) step();
      out_ready = 1'b0;
      n_acc = 0; held_ok = 1'b0; held = '0;
      rand_op(); in_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         if (last_acc) begin n_acc++; rand_op(); end
         if (out_valid && !held_ok) begin
            held = S; held_ok = 1'b1;
         end else if (held_ok) begin
            n_vec++;
            if (S !== held) begin
               n_err++; $display("FAIL bp_hold: got %h want %h", S, held);
            end
         end
      end
      n_vec++;
      if (n_acc != ST) begin
         n_err++; $display("FAIL bp_accepts: got %0d want %0d", n_acc, ST);
      end
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready);
      end
      out_ready = 1'b1;
      n_done = n_acc;
      for (int g = 0; g < 20 && n_done < 6; g++) begin
         step();
         if (last_acc) begin n_done++; rand_op(); end
      end
      in_valid = 1'b0;
      for (int g = 0; g < 30 && got_s.size() < 7; g++) step();
      n_vec++;
      if (got_s.size() != 7 || exp_s.size() != 7) begin
         n_err++; $display("FAIL bp_count: got %0d want 7 (model %0d)", got_s.size(), exp_s.size());
      end else begin
         for (int i = 1; i < 7; i++) begin
            n_vec++;
            if ({got_o[i], got_s[i]} !== {exp_o[i], exp_s[i]}) begin
               n_err++; $display("FAIL bp_result[%0d]: got %h want %h", i, {got_o[i], got_s[i]},
                                 {exp_o[i], exp_s[i]});
            end
            if (i > 1) begin
               n_vec++;
               if (got_c[i] != got_c[i-1] + 1) begin
                  n_err++; $display("FAIL bp_cycle[%0d]: got %0d want %0d", i, got_c[i],
                                    got_c[i-1] + 1);
               end
            end
         end
      end
   endtask

   task automatic test_bubble();
      clear_q();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = (c == 0 || c == 3);
         if (in_valid) rand_op();
         step();
         n_vec++;
         if (last_rdy !== 1'b1) begin
            n_err++; $display("FAIL bubble_in_ready[%0d]: got %b want 1", c, last_rdy);
         end
      end
      n_vec++;
      if (out_valid !== 1'b1 || exp_s.size() != 2) begin
         n_err++; $display("FAIL bubble_head: got valid %b want 1 (model %0d)", out_valid,
                           exp_s.size());
      end else begin
         n_vec++;
         if ({ovf, S} !== {exp_o[0], exp_s[0]}) begin
            n_err++; $display("FAIL bubble_A: got %h want %h", {ovf, S}, {exp_o[0], exp_s[0]});
         end
      end
      out_ready = 1'b1;
      for (int g = 0; g < 10 && got_s.size() < 2; g++) step();
      n_vec++;
      if (got_s.size() != 2 || exp_s.size() != 2) begin
         n_err++; $display("FAIL bubble_count: got %0d want 2", got_s.size());
      end else begin
         n_vec++;
         if ({got_o[1], got_s[1]} !== {exp_o[1], exp_s[1]}) begin
            n_err++; $display("FAIL bubble_B: got %h want %h", {got_o[1], got_s[1]},
                              {exp_o[1], exp_s[1]});
         end
         n_vec++;
         if (got_c[1] != got_c[0] + 1) begin
            n_err++; $display("FAIL bubble_cycle: got %0d want %0d", got_c[1], got_c[0] + 1);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin rand_op(); in_valid = 1'b1; step(); end
      in_valid = 1'b0; out_ready = 1'b0;
      step();
      n_vec++;
      if (out_valid !== 1'b1) begin
         n_err++; $display("FAIL rstmid_pre_valid: got %b want 1", out_valid);
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || {ovf, S} !== 18'h0) begin
         n_err++; $display("FAIL rstmid_async: got valid %b S %h want 0 0", out_valid, {ovf, S});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_q();
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready);
      end
      out_ready = 1'b1;
      @(negedge clk);
      repeat (6) step();
      n_vec++;
      if (got_s.size() != 0) begin
         n_err++; $display("FAIL rstmid_stale: got %0d results want 0", got_s.size());
      end
      rand_op(); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int g = 0; g < 10 && got_s.size() < 1; g++) step();
      n_vec++;
      if (got_s.size() != 1 || exp_s.size() != 1) begin
         n_err++; $display("FAIL rstmid_new: got %0d results want 1", got_s.size());
      end else if ({got_o[0], got_s[0]} !== {exp_o[0], exp_s[0]}) begin
         n_err++; $display("FAIL rstmid_new_val: got %h want %h", {got_o[0], got_s[0]},
                           {exp_o[0], exp_s[0]});
      end
   endtask

   task automatic test_random();
      logic [W-1:0] corner[5];
      corner = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};
      clear_q();
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         rand_op();
         if ($urandom_range(0, 3) == 0) X = corner[$urandom_range(0, 4)];
         if ($urandom_range(0, 3) == 0) Y = corner[$urandom_range(0, 4)];
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int g = 0; g < 20 && got_s.size() < exp_s.size(); g++) step();
      n_vec++;
      if (got_s.size() != exp_s.size()) begin
         n_err++; $display("FAIL rand_count: got %0d want %0d", got_s.size(), exp_s.size());
      end else begin
         for (int i = 0; i < got_s.size(); i++) begin
            n_vec++;
            if ({got_o[i], got_s[i]} !== {exp_o[i], exp_s[i]}) begin
               n_err++; $display("FAIL rand_result[%0d]: got %h want %h", i, {got_o[i], got_s[i]},
                                 {exp_o[i], exp_s[i]});
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_sub();
      test_backpressure();
      test_bubble();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
